// File: rtl/seg_scan_ctrl.sv
// Multiplexed seven-segment scan driver with a clock-enable prescaler, PWM dimming,
// an anti-ghosting dead cycle, and frame-synchronous double-buffered display data.
module seg_scan_ctrl #(
  parameter int DIGITS      = 6,
  parameter int SEG_W       = 7,
  parameter int SCAN_DIV    = 50000,
  parameter int DIM_STEPS   = 8,
  parameter int ENB_ACT_LOW = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [DIGITS*SEG_W-1:0]    i_digit_seg,
  input  logic [DIGITS-1:0]          i_dp,
  input  logic [DIGITS-1:0]          i_blank,
  input  logic [$clog2(DIM_STEPS):0] i_bright,
  input  logic                       i_load,
  output logic [SEG_W-1:0]           o_seg,
  output logic                       o_seg_dp,
  output logic [DIGITS-1:0]          o_seg_enb,
  output logic                       o_frame
);

  localparam int PW   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int STEP = SCAN_DIV / DIM_STEPS;
  localparam int SW   = (STEP > 1) ? $clog2(STEP) : 1;
  localparam int PHW  = (DIM_STEPS > 1) ? $clog2(DIM_STEPS) : 1;
  localparam int BW   = $clog2(DIM_STEPS) + 1;
  localparam int IW   = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [PW-1:0]     PRESC_MAX   = PW'(SCAN_DIV - 1);
  localparam logic [SW-1:0]     STEP_MAX    = SW'(STEP - 1);
  localparam logic [IW-1:0]     IDX_MAX     = IW'(DIGITS - 1);
  localparam logic [BW-1:0]     BRIGHT_FULL = BW'(DIM_STEPS);
  localparam logic [DIGITS-1:0] ENB_IDLE    = {DIGITS{ENB_ACT_LOW != 0}};

  logic [PW-1:0]  presc_q, presc_d;
  logic [SW-1:0]  step_q,  step_d;
  logic [PHW-1:0] ph_q,    ph_d;
  logic [IW-1:0]  idx_q,   idx_d;

  logic [DIGITS-1:0][SEG_W-1:0] seg_pend_q, seg_act_q;
  logic [DIGITS-1:0]            dp_pend_q, dp_act_q;
  logic [DIGITS-1:0]            blank_pend_q, blank_act_q;
  logic [BW-1:0]                bright_pend_q, bright_act_q;

  logic              presc_wrap, step_wrap, frame_end, frame_start, enb_on;
  logic [BW-1:0]     bright_sat;
  logic [DIGITS-1:0] enb_onehot;

  always_comb begin
    // NOTE: every combinational output is assigned unconditionally, so no latch can be inferred.
    presc_wrap  = (presc_q == PRESC_MAX);
    step_wrap   = (step_q == STEP_MAX);
    frame_end   = presc_wrap && (idx_q == IDX_MAX);
    frame_start = (presc_q == '0) && (idx_q == '0);

    presc_d = presc_wrap ? '0 : presc_q + 1'b1;
    step_d  = step_wrap ? '0 : step_q + 1'b1;
    ph_d    = ph_q;
    if (presc_wrap)     ph_d = '0;
    else if (step_wrap) ph_d = ph_q + 1'b1;
    idx_d = idx_q;
    if (presc_wrap) idx_d = (idx_q == IDX_MAX) ? '0 : idx_q + 1'b1;

    // The prescaler==0 cycle is always dark so the previous digit's pattern cannot ghost.
    enb_on     = (presc_q != '0) && (BW'(ph_q) < bright_act_q) && !blank_act_q[idx_q];
    enb_onehot = enb_on ? (DIGITS'(1) << idx_q) : '0;
    bright_sat = (i_bright > BRIGHT_FULL) ? BRIGHT_FULL : i_bright;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_q       <= '0;
      step_q        <= '0;
      ph_q          <= '0;
      idx_q         <= '0;
      seg_pend_q    <= '0;
      dp_pend_q     <= '0;
      blank_pend_q  <= '1;
      bright_pend_q <= BRIGHT_FULL;
      seg_act_q     <= '0;
      dp_act_q      <= '0;
      blank_act_q   <= '1;
      bright_act_q  <= BRIGHT_FULL;
      o_seg         <= '0;
      o_seg_dp      <= 1'b0;
      o_seg_enb     <= ENB_IDLE;
      o_frame       <= 1'b0;
    end else begin
      presc_q <= presc_d;
      step_q  <= step_d;
      ph_q    <= ph_d;
      idx_q   <= idx_d;

      // NOTE: non-blocking updates make active take the pre-load pending value when
      // i_load coincides with the frame boundary; the new data waits one more frame.
      if (frame_end) begin
        seg_act_q    <= seg_pend_q;
        dp_act_q     <= dp_pend_q;
        blank_act_q  <= blank_pend_q;
        bright_act_q <= bright_pend_q;
      end
      if (i_load) begin
        seg_pend_q    <= i_digit_seg;
        dp_pend_q     <= i_dp;
        blank_pend_q  <= i_blank;
        bright_pend_q <= bright_sat;
      end

      o_seg     <= enb_on ? seg_act_q[idx_q] : '0;
      o_seg_dp  <= enb_on ? dp_act_q[idx_q] : 1'b0;
      o_seg_enb <= enb_onehot ^ ENB_IDLE;
      o_frame   <= frame_start;
    end
  end

endmodule
